// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: track/hold, MSB-first binary search on the DAC code, result + done pulse.
// Optional sticky end-of-conversion flag on o_irq when SAR_ADC_IRQ_EN is defined.
module sar_ctrl #(
  parameter int unsigned ADC_RESOLUTION = 8,
  parameter int unsigned SAMPLE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES  = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_comp,
  input  logic                      i_irq_clr,
  output logic                      o_sample,
  output logic [ADC_RESOLUTION-1:0] o_dac_code,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [ADC_RESOLUTION-1:0] o_result,
  output logic                      o_irq
);

  localparam int unsigned N   = ADC_RESOLUTION;
  localparam int unsigned SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int unsigned TCW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned KW  = $clog2(N);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAMPLE  = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0] dac_q, dac_d;
  logic [N-1:0] result_q, result_d;
  logic         sample_q, sample_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [N-1:0] bit_c;
  logic [N-1:0] code_c;

  // Trial bit under test, and the trial code with that bit resolved by the comparator.
  assign bit_c  = N'(1) << k_q;
  assign code_c = i_comp ? dac_q : (dac_q & ~bit_c);

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    tcnt_d   = tcnt_q;
    k_d      = k_q;
    dac_d    = dac_q;
    result_d = result_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dac_d    = '0;
        sample_d = 1'b0;
        busy_d   = 1'b0;
        if (i_start) begin
          state_d  = ST_SAMPLE;
          scnt_d   = '0;
          sample_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (scnt_q == SCW'(SAMPLE_CYCLES - 1)) begin
          state_d  = ST_CONVERT;
          sample_d = 1'b0;
          tcnt_d   = '0;
          k_d      = KW'(N - 1);
          dac_d    = {1'b1, {(N-1){1'b0}}};
        end else begin
          scnt_d = SCW'(scnt_q + 1'b1);
        end
      end
      ST_CONVERT: begin
        // Comparator is only trusted on the last (decision) cycle of each trial.
        if (tcnt_q == TCW'(SETTLE_CYCLES)) begin
          tcnt_d = '0;
          if (k_q == '0) begin
            state_d  = ST_DONE;
            result_d = code_c;
            dac_d    = code_c;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            dac_d = code_c | (bit_c >> 1);
            k_d   = KW'(k_q - 1'b1);
          end
        end else begin
          tcnt_d = TCW'(tcnt_q + 1'b1);
        end
      end
      ST_DONE: begin
        dac_d = '0;
        if (i_start) begin
          state_d  = ST_SAMPLE;
          scnt_d   = '0;
          sample_d = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      scnt_q   <= '0;
      tcnt_q   <= '0;
      k_q      <= '0;
      dac_q    <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      tcnt_q   <= tcnt_d;
      k_q      <= k_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_sample   = sample_q;
  assign o_dac_code = dac_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_result   = result_q;

`ifdef SAR_ADC_IRQ_EN
  logic irq_q, irq_d;

  // Set on entry to and during DONE so a clear coincident with the done pulse loses.
  always_comb begin
    irq_d = done_d | done_q | (irq_q & ~i_irq_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign o_irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = i_irq_clr;
  assign o_irq          = 1'b0;
`endif

endmodule
